// File: rtl/reg_bank_pkg.sv
// Shared state encoding and default sizing for the register bank arbiter.
package reg_bank_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 4;
  localparam int DEPTH_DEF   = 4;

  // 2'd3 is unused and recovers to IDLE in the arbiter FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index after the last grant.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last,
  output logic               any_valid,
  output logic [ID_W-1:0]    grant
);

  int unsigned base;
  int unsigned idx;

  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    base      = {{(32-ID_W){1'b0}}, last};
    idx       = 0;
    // Searching last+1 .. last+NUM_REQ puts the previous winner at lowest priority.
    for (int unsigned k = 1; k <= unsigned'(NUM_REQ); k++) begin
      idx = (base + k) % unsigned'(NUM_REQ);
      if (!any_valid && valid[idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        grant     = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by several requesters through a round-robin arbiter;
// one access per three cycles, all outputs registered.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*$clog2(DEPTH)-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [DATA_W-1:0]                 rsp_rdata
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ID_W   = $clog2(NUM_REQ);

  state_t              state;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     gnt;
  logic [ID_W-1:0]     pick;
  logic                any;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   bank [DEPTH];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid     (req_valid),
    .last      (last),
    .any_valid (any),
    .grant     (pick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= ID_W'(NUM_REQ - 1);
      gnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      bank      <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          req_ready <= '0;
          // The request is consumed here; later input changes cannot reach it.
          if (any) begin
            gnt             <= pick;
            last            <= pick;
            wr_q            <= req_write[pick];
            addr_q          <= req_addr[pick*ADDR_W +: ADDR_W];
            wdata_q         <= req_wdata[pick*DATA_W +: DATA_W];
            req_ready[pick] <= 1'b1;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          req_ready <= '0;
          if (wr_q) begin
            bank[addr_q] <= wdata_q;
            rsp_rdata    <= wdata_q;
          end else begin
            rsp_rdata    <= bank[addr_q];
          end
          rsp_id    <= gnt;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          req_ready <= '0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
